// File: rtl/quad_timer_sched.sv
// Multiplexes the single compare channel of quad_timer among N_CH virtual
// one-shot timers, keeping CMP programmed with the earliest pending deadline.
module quad_timer_sched #(
  parameter int          N_CH        = 4,
  parameter int          GUARD       = 8,
  parameter logic [31:0] TIME_ADDR   = 32'h0000_0000,
  parameter logic [31:0] CMP_ADDR    = 32'h0000_0004,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_0008,
  localparam int         CW          = $clog2(N_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [CW-1:0]   i_req_ch,
  input  logic            i_req_cancel,
  input  logic [31:0]     i_req_delta,
  output logic [N_CH-1:0] o_expired,
  output logic [N_CH-1:0] o_active,
  output logic [31:0]     o_wb_addr,
  output logic [31:0]     o_wb_dat,
  output logic            o_wb_we,
  output logic            o_wb_cyc,
  input  logic [31:0]     i_wb_rdt,
  input  logic            i_irq
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACK   = 3'd1,
    S_RDT   = 3'd2,
    S_SCAN  = 3'd3,
    S_WRCMP = 3'd4,
    S_WREN  = 3'd5,
    S_DIS   = 3'd6
  } state_t;

  localparam logic [31:0]   GUARD_W = 32'(GUARD);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_t          state;
  logic            idle_q;
  logic [CW-1:0]   idx;
  logic [31:0]     now;
  logic [CW-1:0]   req_ch;
  logic            req_cancel;
  logic [31:0]     req_delta;
  logic            req_pend;
  logic            have_cand;
  logic [31:0]     best_d;
  logic [31:0]     best_dl;
  logic [31:0]     deadline [N_CH];
  logic [N_CH-1:0] active;

  logic [31:0]     cur_dl;
  logic [31:0]     diff;
  logic            hit;
  logic            take;
  logic            next_cand;
  logic [31:0]     next_dl;
  logic [N_CH-1:0] expired;

  // Scan datapath: the modular difference alone decides expiry and ordering across wrap.
  always_comb begin
    cur_dl    = deadline[idx];
    diff      = cur_dl - now;
    hit       = 1'b0;
    take      = 1'b0;
    expired   = '0;
    if (state == S_SCAN && active[idx]) begin
      if ($signed(diff) <= $signed(GUARD_W)) begin
        hit = 1'b1;
      end else if (!have_cand || diff < best_d) begin
        take = 1'b1;
      end else begin
        take = 1'b0;
      end
    end else begin
      hit  = 1'b0;
      take = 1'b0;
    end
    if (hit) begin
      expired[idx] = 1'b1;
    end else begin
      expired = '0;
    end
    next_cand = have_cand | take;
    next_dl   = take ? cur_dl : best_dl;
  end

  assign o_expired   = expired;
  assign o_active    = active;
  assign o_req_ready = idle_q & ~i_irq;

  // Controller FSM; bus outputs are registered and set on entry to each access state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      idle_q     <= 1'b0;
      idx        <= '0;
      now        <= 32'h0000_0000;
      req_ch     <= '0;
      req_cancel <= 1'b0;
      req_delta  <= 32'h0000_0000;
      req_pend   <= 1'b0;
      have_cand  <= 1'b0;
      best_d     <= 32'h0000_0000;
      best_dl    <= 32'h0000_0000;
      active     <= '0;
      for (int c = 0; c < N_CH; c++) deadline[c] <= 32'h0000_0000;
      o_wb_addr  <= 32'h0000_0000;
      o_wb_dat   <= 32'h0000_0000;
      o_wb_we    <= 1'b0;
      o_wb_cyc   <= 1'b0;
    end else begin
      o_wb_addr <= 32'h0000_0000;
      o_wb_dat  <= 32'h0000_0000;
      o_wb_we   <= 1'b0;
      o_wb_cyc  <= 1'b0;
      idle_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_irq) begin
            state     <= S_ACK;
            o_wb_cyc  <= 1'b1;
            o_wb_we   <= 1'b1;
            o_wb_addr <= STATUS_ADDR;
          end else if (i_req_valid && idle_q) begin
            state      <= S_RDT;
            req_ch     <= i_req_ch;
            req_cancel <= i_req_cancel;
            req_delta  <= i_req_delta;
            req_pend   <= 1'b1;
            o_wb_cyc   <= 1'b1;
            o_wb_addr  <= TIME_ADDR;
          end else begin
            idle_q <= 1'b1;
          end
        end
        S_ACK: begin
          state     <= S_RDT;
          o_wb_cyc  <= 1'b1;
          o_wb_addr <= TIME_ADDR;
        end
        S_RDT: begin
          now       <= i_wb_rdt;
          idx       <= '0;
          have_cand <= 1'b0;
          best_d    <= 32'h0000_0000;
          best_dl   <= 32'h0000_0000;
          req_pend  <= 1'b0;
          state     <= S_SCAN;
          if (req_pend && req_cancel) begin
            active[req_ch] <= 1'b0;
          end else if (req_pend) begin
            active[req_ch]   <= 1'b1;
            deadline[req_ch] <= i_wb_rdt + req_delta;
          end
        end
        S_SCAN: begin
          if (hit) active[idx] <= 1'b0;
          have_cand <= next_cand;
          best_dl   <= next_dl;
          if (take) best_d <= diff;
          if (idx == LAST_CH) begin
            o_wb_cyc <= 1'b1;
            o_wb_we  <= 1'b1;
            if (next_cand) begin
              state     <= S_WRCMP;
              o_wb_addr <= CMP_ADDR;
              o_wb_dat  <= next_dl;
            end else begin
              state     <= S_DIS;
              o_wb_addr <= STATUS_ADDR;
            end
          end else begin
            idx <= idx + CW'(1);
          end
        end
        S_WRCMP: begin
          state     <= S_WREN;
          o_wb_cyc  <= 1'b1;
          o_wb_we   <= 1'b1;
          o_wb_addr <= STATUS_ADDR;
          o_wb_dat  <= 32'h0000_0001;
        end
        S_WREN: begin
          state  <= S_IDLE;
          idle_q <= 1'b1;
        end
        S_DIS: begin
          state  <= S_IDLE;
          idle_q <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
